// File: rtl/switch_cfg_loader_pkg.sv
// Shared constants and types for the switch configuration loader
// and the switch matrix that consumes its configuration words.
package switch_cfg_loader_pkg;

  localparam int WORD_W  = 6;
  localparam int N_TB    = 5;
  localparam int N_LR    = 4;
  localparam int N_WORDS = 2*N_TB + 2*N_LR;
  localparam int CFG_W   = N_WORDS*WORD_W;

  localparam logic [7:0] SYNC = 8'hA5;

  localparam logic [2:0] SEL_OFF    = 3'd0;
  localparam logic [2:0] SEL_TOP    = 3'd1;
  localparam logic [2:0] SEL_RIGHT  = 3'd2;
  localparam logic [2:0] SEL_BOTTOM = 3'd3;
  localparam logic [2:0] SEL_LEFT   = 3'd4;

  localparam int IDX_TOP0    = 0;
  localparam int IDX_BOTTOM0 = N_TB;
  localparam int IDX_LEFT0   = 2*N_TB;
  localparam int IDX_RIGHT0  = 2*N_TB + N_LR;

  typedef enum logic [1:0] {
    HUNT,
    LOAD,
    CKSUM,
    COMMIT
  } state_e;

endpackage

// File: rtl/switch_cfg_loader_cfg_shift_xor.sv
// Serial-to-word shifter: packs MSB-first bits into words, stacks
// them into a shadow image and keeps a running XOR of the words.
module cfg_shift_xor
  import switch_cfg_loader_pkg::*;
#(
  parameter int W = WORD_W,
  parameter int N = N_WORDS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic           bit_i,
  output logic [N*W-1:0] shadow_o,
  output logic [W-1:0]   xor_o,
  output logic           last_o
);

  localparam int BW = $clog2(W+1);
  localparam int NCW = $clog2(N+1);

  logic [BW-1:0]  bit_cnt_q;
  logic [NCW-1:0] word_cnt_q;
  logic [W-1:0]   word_q;
  logic [W-1:0]   xor_q;
  logic [N*W-1:0] shadow_q;
  logic [W-1:0]   word_d;
  logic           wrap;

  assign word_d = {word_q[W-2:0], bit_i};
  assign wrap   = (bit_cnt_q == BW'(W-1));
  assign last_o = en_i && wrap && (word_cnt_q == NCW'(N-1));

  assign shadow_o = shadow_q;
  assign xor_o    = xor_q;

  // Completed words enter at the top so word 0 ends up lowest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      word_q     <= '0;
      xor_q      <= '0;
      shadow_q   <= '0;
    end else if (clr_i) begin
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      word_q     <= '0;
      xor_q      <= '0;
      shadow_q   <= '0;
    end else if (en_i) begin
      word_q <= word_d;
      if (wrap) begin
        bit_cnt_q  <= '0;
        word_cnt_q <= word_cnt_q + 1'b1;
        xor_q      <= xor_q ^ word_d;
        shadow_q   <= {word_d, shadow_q[N*W-1:W]};
      end else begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_cfg_loader.sv
// Serial frame loader for the switch matrix: hunts SYNC, loads
// 18 words, checks the XOR checksum and commits atomically.
module switch_cfg_loader #(
  parameter int         N_TB   = 5,
  parameter int         N_LR   = 4,
  parameter int         WORD_W = 6,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_bit,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic cfg_clear,
  output logic [(2*N_TB+2*N_LR)*WORD_W-1:0] cfg_words,
  output logic cfg_loaded,
  output logic cfg_done,
  output logic cfg_err
);

  import switch_cfg_loader_pkg::state_e;
  import switch_cfg_loader_pkg::HUNT;
  import switch_cfg_loader_pkg::LOAD;
  import switch_cfg_loader_pkg::CKSUM;
  import switch_cfg_loader_pkg::COMMIT;

  localparam int NW = 2*N_TB + 2*N_LR;
  localparam int CW = NW*WORD_W;
  localparam int KW = $clog2(WORD_W+1);

  state_e          state_q;
  logic [7:0]      win_q;
  logic [KW-1:0]   ck_cnt_q;
  logic [CW-1:0]   words_q;
  logic            loaded_q;
  logic            done_q;
  logic            err_q;

  logic            acc;
  logic [7:0]      win_d;
  logic            sync_hit;
  logic            sx_clr;
  logic            sx_en;
  logic            sx_last;
  logic [CW-1:0]   shadow;
  logic [WORD_W-1:0] sx_xor;

  assign acc      = cfg_valid && (state_q != COMMIT);
  assign win_d    = {win_q[6:0], cfg_bit};
  assign sync_hit = acc && (state_q == HUNT) && (win_d == SYNC);
  assign sx_clr   = cfg_clear || sync_hit;
  assign sx_en    = acc && (state_q == LOAD);

  cfg_shift_xor #(
    .W (WORD_W),
    .N (NW)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (sx_clr),
    .en_i     (sx_en),
    .bit_i    (cfg_bit),
    .shadow_o (shadow),
    .xor_o    (sx_xor),
    .last_o   (sx_last)
  );

  // The sync window doubles as the checksum shifter (WORD_W <= 8).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      win_q    <= '0;
      ck_cnt_q <= '0;
      words_q  <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cfg_clear) begin
        state_q  <= HUNT;
        win_q    <= '0;
        ck_cnt_q <= '0;
        words_q  <= '0;
        loaded_q <= 1'b0;
      end else begin
        unique case (state_q)
          HUNT: begin
            if (acc) begin
              win_q <= sync_hit ? 8'h00 : win_d;
              if (sync_hit) state_q <= LOAD;
            end
          end
          LOAD: begin
            if (sx_last) begin
              state_q  <= CKSUM;
              ck_cnt_q <= '0;
            end
          end
          CKSUM: begin
            if (acc) begin
              win_q    <= win_d;
              ck_cnt_q <= ck_cnt_q + 1'b1;
              if (ck_cnt_q == KW'(WORD_W-1)) begin
                win_q <= '0;
                if (win_d[WORD_W-1:0] == sx_xor) begin
                  state_q  <= COMMIT;
                  words_q  <= shadow;
                  done_q   <= 1'b1;
                  loaded_q <= 1'b1;
                end else begin
                  state_q <= HUNT;
                  err_q   <= 1'b1;
                end
              end
            end
          end
          COMMIT: state_q <= HUNT;
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign cfg_ready  = (state_q != COMMIT);
  assign cfg_words  = words_q;
  assign cfg_loaded = loaded_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_switch_cfg_loader.sv
// Self-checking bench for switch_cfg_loader: frame table plus
// hand sequences for reset and clear, with an event scoreboard.
module tb_switch_cfg_loader;
  import switch_cfg_loader_pkg::*;

  localparam int NWD = 18;
  localparam int CWD = 108;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_bit;
  logic           cfg_valid;
  logic           cfg_ready;
  logic           cfg_clear;
  logic [CWD-1:0] cfg_words;
  logic           cfg_loaded;
  logic           cfg_done;
  logic           cfg_err;

  always #5 clk = ~clk;

  switch_cfg_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_bit    (cfg_bit),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_clear  (cfg_clear),
    .cfg_words  (cfg_words),
    .cfg_loaded (cfg_loaded),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  typedef struct packed {
    logic           done;
    logic           err;
    logic [CWD-1:0] words;
  } ev_t;

  typedef struct {
    logic [5:0] base;
    logic [5:0] step;
    logic [5:0] corrupt;
    bit         pre;
    bit         gaps;
    bit         ok;
  } vec_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  errors = 0;

  always @(negedge clk)
    if (rst_n && (cfg_done || cfg_err))
      obs_q.push_back({cfg_done, cfg_err, cfg_words});

  task automatic chk(input string nm, input logic [CWD-1:0] act,
                     input logic [CWD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] word_at(input logic [5:0] base,
                                         input logic [5:0] step,
                                         input int k);
    return base + step * 6'(k);
  endfunction

  function automatic logic [CWD-1:0] build_img(input logic [5:0] base,
                                               input logic [5:0] step);
    logic [CWD-1:0] img;
    img = '0;
    for (int k = 0; k < NWD; k++) img[6*k +: 6] = word_at(base, step, k);
    return img;
  endfunction

  task automatic send_bit(input logic b, input bit gaps, input logic clr);
    int n;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      cfg_valid = 1'b0;
      cfg_bit   = 1'($urandom);
      @(negedge clk);
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    cfg_clear = clr;
    n = 0;
    while (!cfg_ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1");
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_clear = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gaps, 1'b0);
  endtask

  task automatic send_word(input logic [5:0] w, input bit gaps,
                           input bit clr_last);
    for (int i = 5; i >= 0; i--)
      send_bit(w[i], gaps, (clr_last && i == 0));
  endtask

  task automatic send_frame(input logic [5:0] base, input logic [5:0] step,
                            input logic [5:0] corrupt, input bit pre,
                            input bit gaps, input bit clr_last);
    logic [5:0] x;
    logic [5:0] w;
    if (pre) begin
      send_byte(8'h5A, gaps);
      send_byte(8'hFF, gaps);
    end
    send_byte(SYNC, gaps);
    x = '0;
    for (int k = 0; k < NWD; k++) begin
      w = word_at(base, step, k);
      x = x ^ w;
      send_word(w, gaps, 1'b0);
    end
    send_word(x ^ corrupt, gaps, clr_last);
  endtask

  task automatic drain();
    ev_t e;
    ev_t o;
    int  t;
    t = 0;
    while (exp_q.size() > 0 && t < 40) begin
      if (obs_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        chk("ev_kind", {o.done, o.err}, {e.done, e.err});
        chk("ev_words", o.words, e.words);
      end else begin
        @(negedge clk);
        t++;
      end
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL ev_timeout: got no event expected %0d", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL spurious_ev: got %0d events expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t           tv[6];
    logic [CWD-1:0] m_words;
    logic           m_loaded;
    logic [CWD-1:0] img;

    tv[0] = '{6'h09, 6'h00, 6'h01, 1'b0, 1'b0, 1'b0};
    tv[1] = '{6'h09, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1};
    tv[2] = '{6'h12, 6'h05, 6'h00, 1'b1, 1'b1, 1'b1};
    tv[3] = '{6'h29, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1};
    tv[4] = '{6'h3F, 6'h00, 6'h20, 1'b0, 1'b1, 1'b0};
    tv[5] = '{6'h3F, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    cfg_bit = 1'b0;
    cfg_valid = 1'b0;
    cfg_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_words", cfg_words, '0);
    chk("rst_loaded", 108'(cfg_loaded), 108'd0);
    chk("rst_done", 108'(cfg_done), 108'd0);
    chk("rst_err", 108'(cfg_err), 108'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 108'(cfg_ready), 108'd1);

    m_words = '0;
    m_loaded = 1'b0;
    for (int i = 0; i < 6; i++) begin
      img = build_img(tv[i].base, tv[i].step);
      if (tv[i].ok) begin
        m_words = img;
        m_loaded = 1'b1;
        exp_q.push_back({1'b1, 1'b0, img});
      end else begin
        exp_q.push_back({1'b0, 1'b1, m_words});
      end
      send_frame(tv[i].base, tv[i].step, tv[i].corrupt,
                 tv[i].pre, tv[i].gaps, 1'b0);
      chk("commit_ready", 108'(cfg_ready), 108'(!tv[i].ok));
      chk("done_now", 108'(cfg_done), 108'(tv[i].ok));
      chk("err_now", 108'(cfg_err), 108'(!tv[i].ok));
      drain();
      chk("tbl_words", cfg_words, m_words);
      chk("tbl_loaded", 108'(cfg_loaded), 108'(m_loaded));
    end

    send_byte(SYNC, 1'b0);
    for (int k = 0; k < 10; k++) send_word(6'h15, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_words", cfg_words, '0);
    chk("midrst_loaded", 108'(cfg_loaded), 108'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_words = '0;
    m_loaded = 1'b0;
    for (int k = 10; k < NWD; k++) send_word(6'h15, 1'b0, 1'b0);
    send_word(6'h00, 1'b0, 1'b0);
    drain();
    chk("tail_words", cfg_words, '0);
    img = build_img(6'h15, 6'h00);
    m_words = img;
    m_loaded = 1'b1;
    exp_q.push_back({1'b1, 1'b0, img});
    send_frame(6'h15, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    drain();
    chk("postrst_words", cfg_words, m_words);
    chk("postrst_loaded", 108'(cfg_loaded), 108'(m_loaded));

    send_frame(6'h0C, 6'h03, 6'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_done", 108'(cfg_done), 108'd0);
    chk("clr_ready", 108'(cfg_ready), 108'd1);
    drain();
    chk("clr_words", cfg_words, '0);
    chk("clr_loaded", 108'(cfg_loaded), 108'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
